// File: rtl/corefifo_fwft_axis_bridge.sv
// corefifo_fwft_axis_bridge: FWFT-to-valid/ready bridge with a 2-entry skid buffer and optional tlast framing.
// Optional framing is enabled by defining CoreFIFO_FWFT_AXIS_PKT_EN.
module corefifo_fwft_axis_bridge #(
  parameter int RWIDTH   = 10,
  parameter int PKT_LEN  = 16,
  parameter bit READ_LOW = 1
) (
  input  logic              pos_rclk,
  input  logic              aresetn_rclk,
  input  logic              sresetn_rclk,
  input  logic              fifo_empty,
  input  logic [RWIDTH-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [RWIDTH-1:0] m_tdata,
  output logic              m_tlast,
  output logic [15:0]       pkt_cnt
);
  if (PKT_LEN < 1 || PKT_LEN > 65535) begin : g_pkt_len_chk
    $error("PKT_LEN must be in 1..65535");
  end
  logic [1:0]        cnt_q, cnt_d;
  logic [RWIDTH-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic              pop, acc, fill0, fill1;
  // Pop is held off during reset so the FWFT stage keeps its head word.
  assign pop        = aresetn_rclk && sresetn_rclk && !fifo_empty && cnt_q != 2'd2;
  assign fifo_rd_en = READ_LOW ? !pop : pop;
  assign acc        = m_tvalid && m_tready;
  assign fill0      = pop && (cnt_q == 2'd0 || acc);
  assign fill1      = pop && !acc && cnt_q == 2'd1;
  assign m_tvalid   = cnt_q != 2'd0;
  assign m_tdata    = slot0_q;
  always_comb begin
    cnt_d   = !sresetn_rclk ? 2'd0 : cnt_q + 2'(pop && !acc) - 2'(acc && !pop);
    slot0_d = !sresetn_rclk ? '0 : fill0 ? fifo_dout : acc ? slot1_q : slot0_q;
    slot1_d = !sresetn_rclk ? '0 : fill1 ? fifo_dout : slot1_q;
  end
  always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      cnt_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end
`ifdef CoreFIFO_FWFT_AXIS_PKT_EN
  localparam logic [15:0] LAST = 16'(PKT_LEN - 1);
  logic        last0_q, last0_d, last1_q, last1_d, plast;
  logic [15:0] pidx_q, pidx_d, wcnt_q, wcnt_d, pkt_q, pkt_d;
  // pidx tracks the packet index of the next word to be pushed; tlast travels with the word.
  assign plast   = pidx_q == LAST;
  assign m_tlast = m_tvalid && last0_q;
  assign pkt_cnt = pkt_q;
  always_comb begin
    pidx_d  = !sresetn_rclk ? 16'd0 : pop ? (plast ? 16'd0 : pidx_q + 16'd1) : pidx_q;
    last0_d = !sresetn_rclk ? 1'b0 : fill0 ? plast : acc ? last1_q : last0_q;
    last1_d = !sresetn_rclk ? 1'b0 : fill1 ? plast : last1_q;
    wcnt_d  = !sresetn_rclk ? 16'd0 : acc ? (last0_q ? 16'd0 : wcnt_q + 16'd1) : wcnt_q;
    pkt_d   = !sresetn_rclk ? 16'd0 : (acc && last0_q) ? pkt_q + 16'd1 : pkt_q;
  end
  always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      pidx_q  <= 16'd0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      wcnt_q  <= 16'd0;
      pkt_q   <= 16'd0;
    end else begin
      pidx_q  <= pidx_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      wcnt_q  <= wcnt_d;
      pkt_q   <= pkt_d;
    end
  end
`else
  assign m_tlast = 1'b0;
  assign pkt_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_corefifo_fwft_axis_bridge.sv
// tb_corefifo_fwft_axis_bridge: directed scoreboard bench for the FWFT-to-stream bridge.
module tb_corefifo_fwft_axis_bridge;
  localparam int PLEN = 4;
  localparam bit PK =
`ifdef CoreFIFO_FWFT_AXIS_PKT_EN
    1'b1;
`else
    1'b0;
`endif
  logic        clk, aresetn_rclk, sresetn_rclk, fifo_empty, fifo_rd_en;
  logic        m_tvalid, m_tready, m_tlast;
  logic [9:0]  fifo_dout, m_tdata;
  logic [15:0] pkt_cnt;
  logic [9:0]  src[$];
  logic [9:0]  exp_q[$];
  int          inflight, kacc, pkt_m, n_chk, n_fail;
  corefifo_fwft_axis_bridge #(.RWIDTH(10), .PKT_LEN(PLEN), .READ_LOW(1'b1)) dut (
    .pos_rclk(clk), .aresetn_rclk(aresetn_rclk), .sresetn_rclk(sresetn_rclk),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .pkt_cnt(pkt_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic upd_src();
    fifo_empty = src.size() == 0;
    fifo_dout  = src.size() != 0 ? src[0] : 10'h3FF;
  endtask
  task automatic push(input logic [9:0] w);
    src.push_back(w);
    exp_q.push_back(w);
    upd_src();
  endtask
  task automatic drop_buffered();
    repeat (inflight) void'(exp_q.pop_front());
    inflight = 0;
    kacc     = 0;
    pkt_m    = 0;
  endtask
  task automatic cyc();
    logic pe, ac, el;
    @(negedge clk);
    pe = src.size() != 0 && inflight != 2 && sresetn_rclk;
    ac = inflight != 0 && m_tready && sresetn_rclk;
    el = PK && (kacc % PLEN == PLEN - 1);
    chk("rd_en", 32'(fifo_rd_en), 32'(!pe));
    chk("tvalid", 32'(m_tvalid), 32'(inflight != 0));
    if (inflight != 0) begin
      chk("tdata", 32'(m_tdata), 32'(exp_q[0]));
      chk("tlast", 32'(m_tlast), 32'(el));
    end
    @(posedge clk);
    #1;
    if (!sresetn_rclk) drop_buffered();
    else begin
      if (ac) begin
        void'(exp_q.pop_front());
        inflight--;
        kacc  = el ? 0 : kacc + 1;
        pkt_m = el ? pkt_m + 1 : pkt_m;
      end
      if (pe) begin
        void'(src.pop_front());
        inflight++;
      end
    end
    upd_src();
  endtask
  task automatic drain(input string tag);
    m_tready = 1'b1;
    for (int i = 0; i < 60 && (exp_q.size() != 0); i++) cyc();
    chk(tag, 32'(exp_q.size()), 32'd0);
    chk({tag, "_pkt"}, 32'(pkt_cnt), 32'(pkt_m));
  endtask
  task automatic arst();
    aresetn_rclk = 1'b0;
    #1;
    chk("arst_tvalid", 32'(m_tvalid), 32'd0);
    chk("arst_tdata", 32'(m_tdata), 32'd0);
    chk("arst_tlast", 32'(m_tlast), 32'd0);
    chk("arst_pkt", 32'(pkt_cnt), 32'd0);
    #1;
    aresetn_rclk = 1'b1;
    drop_buffered();
  endtask
  initial begin
    n_chk = 0; n_fail = 0; inflight = 0; kacc = 0; pkt_m = 0;
    aresetn_rclk = 1'b0; sresetn_rclk = 1'b1; m_tready = 1'b1;
    upd_src();
    push(10'h0A1); push(10'h0B2); push(10'h0C3);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_pkt", 32'(pkt_cnt), 32'd0);
    aresetn_rclk = 1'b1;
    drain("t1_abc");
    arst();
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) push(10'(10'h100 + i));
    repeat (6) cyc();
    chk("t2_stall_src", 32'(src.size()), 32'd3);
    drain("t2_drain");
    arst();
    for (int i = 0; i < 8; i++) push(10'(10'h200 + i * 3));
    for (int i = 0; i < 24; i++) begin
      m_tready = ~i[0];
      cyc();
    end
    drain("t3_toggle");
    arst();
    for (int i = 0; i < 10; i++) push(10'(10'h040 + i));
    drain("t4_ten");
    chk("t4_pkt2", 32'(pkt_cnt), PK ? 32'd2 : 32'd0);
    arst();
    for (int i = 0; i < 4; i++) push(10'(10'h060 + i));
    drain("t4_four");
    chk("t4_pkt1", 32'(pkt_cnt), PK ? 32'd1 : 32'd0);
    for (int i = 0; i < 5; i++) push(10'(10'h300 + i));
    repeat (3) cyc();
    m_tready = 1'b0;
    repeat (3) cyc();
    chk("t5_full", 32'(inflight), 32'd2);
    sresetn_rclk = 1'b0;
    cyc();
    sresetn_rclk = 1'b1;
    #1;
    chk("t5_tvalid", 32'(m_tvalid), 32'd0);
    chk("t5_pkt", 32'(pkt_cnt), 32'd0);
    for (int i = 0; i < 3; i++) push(10'(10'h380 + i));
    drain("t5_newpkt");
    chk("t5_pkt1", 32'(pkt_cnt), PK ? 32'd1 : 32'd0);
    m_tready = 1'b1;
    repeat (5) cyc();
    chk("t6_rd_en", 32'(fifo_rd_en), 32'd1);
    chk("t6_tvalid", 32'(m_tvalid), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
